// File: rtl/mc_init_seq_if.sv
// Signals between the SDRAM init sequencer, the per-CS register files, the
// main controller's bus arbiter and the pin driver.
interface mc_init_seq_if #(
    parameter int N_CS = 8
);
    logic [N_CS-1:0] init_req;
    logic [N_CS-1:0] lmr_req;
    logic [N_CS-1:0] init_ack;
    logic [N_CS-1:0] lmr_ack;
    logic [2:0]      cs_sel;
    logic [31:0]     tms;
    logic            bus_req;
    logic            bus_gnt;
    logic [2:0]      cmd;
    logic            cmd_valid;
    logic            cmd_ready;
    logic [N_CS-1:0] cmd_cs;
    logic [12:0]     mode_val;

    modport master (
        input  init_req, lmr_req, tms, bus_gnt, cmd_ready,
        output init_ack, lmr_ack, cs_sel, bus_req, cmd, cmd_valid, cmd_cs, mode_val
    );

    modport slave (
        output init_req, lmr_req, tms, bus_gnt, cmd_ready,
        input  init_ack, lmr_ack, cs_sel, bus_req, cmd, cmd_valid, cmd_cs, mode_val
    );
endinterface

// File: rtl/mc_init_seq.sv
// SDRAM power-up / load-mode sequencer: arbitrates per-CS requests, takes the
// memory bus, issues PRECHARGE-ALL / AUTO-REFRESH / LOAD-MODE and acks the CS.
module mc_init_seq #(
    parameter int N_CS    = 8,
    parameter int REF_CNT = 2,
    parameter int TMRD    = 2
) (
    input  logic          clk,
    input  logic          rst,
    mc_init_seq_if.master bus
);
    localparam logic [2:0] CMD_NOP = 3'b000;
    localparam logic [2:0] CMD_PRE = 3'b001;
    localparam logic [2:0] CMD_REF = 3'b010;
    localparam logic [2:0] CMD_LMR = 3'b011;

    typedef enum logic [3:0] {
        S_IDLE, S_WAIT_GNT, S_PRE, S_TRP, S_REF, S_TRFC, S_LMR, S_TMRD, S_ACK
    } state_t;

    state_t          state, state_nxt;
    logic [3:0]      timer, timer_d;
    logic [3:0]      ref_cnt, ref_d;
    logic [3:0]      trp_l, trfc_l;
    logic [12:0]     mode_l;
    logic            kind_init, kind_d;
    logic            accept;

    logic [N_CS-1:0] init_ack_q, init_ack_d;
    logic [N_CS-1:0] lmr_ack_q, lmr_ack_d;
    logic [2:0]      cs_sel_q, cs_sel_d;
    logic            bus_req_q, bus_req_d;
    logic [2:0]      cmd_q, cmd_d;
    logic            cmd_valid_q, cmd_valid_d;
    logic [N_CS-1:0] cmd_cs_q, cmd_cs_d;
    logic [12:0]     mode_val_q, mode_val_d;

    logic            arb_hit, arb_init;
    logic [2:0]      arb_idx;

    assign accept = cmd_valid_q & bus.cmd_ready;

    // Fixed priority: any init beats any lmr, lowest index wins within a class.
    always_comb begin
        arb_hit  = 1'b0;
        arb_init = 1'b0;
        arb_idx  = 3'd0;
        for (int i = N_CS - 1; i >= 0; i--) begin
            if (bus.lmr_req[i]) begin
                arb_hit = 1'b1;
                arb_idx = 3'(i);
            end
        end
        for (int i = N_CS - 1; i >= 0; i--) begin
            if (bus.init_req[i]) begin
                arb_hit  = 1'b1;
                arb_init = 1'b1;
                arb_idx  = 3'(i);
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state       <= S_IDLE;
            timer       <= '0;
            ref_cnt     <= '0;
            trp_l       <= '0;
            trfc_l      <= '0;
            mode_l      <= '0;
            kind_init   <= 1'b0;
            init_ack_q  <= '0;
            lmr_ack_q   <= '0;
            cs_sel_q    <= '0;
            bus_req_q   <= 1'b0;
            cmd_q       <= CMD_NOP;
            cmd_valid_q <= 1'b0;
            cmd_cs_q    <= '0;
            mode_val_q  <= '0;
        end else begin
            state       <= state_nxt;
            timer       <= timer_d;
            ref_cnt     <= ref_d;
            kind_init   <= kind_d;
            init_ack_q  <= init_ack_d;
            lmr_ack_q   <= lmr_ack_d;
            cs_sel_q    <= cs_sel_d;
            bus_req_q   <= bus_req_d;
            cmd_q       <= cmd_d;
            cmd_valid_q <= cmd_valid_d;
            cmd_cs_q    <= cmd_cs_d;
            mode_val_q  <= mode_val_d;
            // Timing snapshot taken in the grant cycle; later tms changes are ignored.
            if (state == S_WAIT_GNT && bus.bus_gnt) begin
                trp_l  <= bus.tms[23:20];
                trfc_l <= bus.tms[27:24];
                mode_l <= bus.tms[12:0];
            end
        end
    end

    always_comb begin
        state_nxt = state;
        timer_d   = timer;
        ref_d     = ref_cnt;
        case (state)
            S_IDLE:     if (arb_hit) state_nxt = S_WAIT_GNT;
            S_WAIT_GNT: if (bus.bus_gnt) begin
                state_nxt = S_PRE;
                ref_d     = '0;
            end
            S_PRE:      if (accept) begin
                state_nxt = S_TRP;
                timer_d   = trp_l;
            end
            S_TRP:      if (timer == 4'd0) state_nxt = kind_init ? S_REF : S_LMR;
                        else timer_d = timer - 4'd1;
            S_REF:      if (accept) begin
                state_nxt = S_TRFC;
                ref_d     = ref_cnt + 4'd1;
                timer_d   = trfc_l;
            end
            S_TRFC:     if (timer == 4'd0) state_nxt = (ref_cnt < 4'(REF_CNT)) ? S_REF : S_LMR;
                        else timer_d = timer - 4'd1;
            S_LMR:      if (accept) begin
                state_nxt = S_TMRD;
                timer_d   = 4'(TMRD - 1);
            end
            S_TMRD:     if (timer == 4'd0) state_nxt = S_ACK;
                        else timer_d = timer - 4'd1;
            S_ACK:      state_nxt = S_IDLE;
            default:    state_nxt = S_IDLE;
        endcase
    end

    // Output values are decoded from the next state so they register in step with it.
    always_comb begin
        bus_req_d   = !(state_nxt inside {S_IDLE, S_ACK});
        cmd_valid_d = state_nxt inside {S_PRE, S_REF, S_LMR};
        case (state_nxt)
            S_PRE:   cmd_d = CMD_PRE;
            S_REF:   cmd_d = CMD_REF;
            S_LMR:   cmd_d = CMD_LMR;
            default: cmd_d = CMD_NOP;
        endcase
        init_ack_d = '0;
        lmr_ack_d  = '0;
        if (state_nxt == S_ACK) begin
            if (kind_init) init_ack_d = N_CS'(1) << cs_sel_q;
            else           lmr_ack_d  = N_CS'(1) << cs_sel_q;
        end
        cs_sel_d = cs_sel_q;
        kind_d   = kind_init;
        cmd_cs_d = cmd_cs_q;
        if (state == S_IDLE && state_nxt == S_WAIT_GNT) begin
            cs_sel_d = arb_idx;
            kind_d   = arb_init;
            cmd_cs_d = N_CS'(1) << arb_idx;
        end else if (!bus_req_d) begin
            cmd_cs_d = '0;
        end
        mode_val_d = (state_nxt == S_LMR) ? mode_l : mode_val_q;
    end

    assign bus.init_ack  = init_ack_q;
    assign bus.lmr_ack   = lmr_ack_q;
    assign bus.cs_sel    = cs_sel_q;
    assign bus.bus_req   = bus_req_q;
    assign bus.cmd       = cmd_q;
    assign bus.cmd_valid = cmd_valid_q;
    assign bus.cmd_cs    = cmd_cs_q;
    assign bus.mode_val  = mode_val_q;
endmodule

// File: tb/tb_mc_init_seq.sv
// Directed bench for mc_init_seq: table of request/timing vectors, each served
// as one full sequence and compared cycle by cycle, plus a mid-sequence reset.
module tb_mc_init_seq;
    localparam int N_CS    = 8;
    localparam int REF_CNT = 2;
    localparam int TMRD    = 2;
    // {cmd_valid, cmd} per cycle
    localparam logic [3:0] V_NOP = 4'h0;
    localparam logic [3:0] V_PRE = 4'h9;
    localparam logic [3:0] V_REF = 4'hA;
    localparam logic [3:0] V_LMR = 4'hB;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    mc_init_seq_if #(.N_CS(N_CS)) bus ();

    mc_init_seq #(.N_CS(N_CS), .REF_CNT(REF_CNT), .TMRD(TMRD)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    typedef struct {
        logic [7:0]  init_set;
        logic [7:0]  lmr_set;
        logic [31:0] tms;
        logic [2:0]  exp_sel;
        logic        exp_init;
        int          stall;
        bit          chg_tms;
        bit          chk_lat;
    } vec_t;

    vec_t       vecs [8];
    int         checks     = 0;
    int         failures   = 0;
    int         ack_pulses = 0;
    int         multi_ack  = 0;
    int         seqs       = 0;
    logic [7:0] init_pend  = '0;
    logic [7:0] lmr_pend   = '0;

    always @(negedge clk) begin
        if (rst) begin
            if ($countones({bus.init_ack, bus.lmr_ack}) > 1) multi_ack++;
            ack_pulses += $countones({bus.init_ack, bus.lmr_ack});
        end
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic serve(input vec_t v);
        logic [3:0] exp_q[$];
        logic [3:0] obs;
        logic [7:0] oh;
        int         n, bad, stall_left;
        bit         stalled;
        oh = 8'h01 << v.exp_sel;
        init_pend |= v.init_set;
        lmr_pend  |= v.lmr_set;
        bus.init_req = init_pend;
        bus.lmr_req  = lmr_pend;
        bus.tms      = v.tms;
        n = 0;
        while (bus.bus_req !== 1'b1 && n < 40) begin
            @(negedge clk);
            n++;
        end
        chk("bus_req_rise", 64'(bus.bus_req), 64'd1);
        if (v.chk_lat) chk("rearb_latency", 64'(n), 64'd2);
        chk("cs_sel", 64'(bus.cs_sel), 64'(v.exp_sel));
        chk("cmd_cs_arb", 64'(bus.cmd_cs), 64'(oh));
        @(negedge clk);
        bus.bus_gnt = 1'b1;

        exp_q.push_back(V_PRE);
        repeat (int'(v.tms[23:20]) + 1) exp_q.push_back(V_NOP);
        if (v.exp_init) begin
            for (int r = 0; r < REF_CNT; r++) begin
                exp_q.push_back(V_REF);
                if (r == 0) repeat (v.stall) exp_q.push_back(V_REF);
                repeat (int'(v.tms[27:24]) + 1) exp_q.push_back(V_NOP);
            end
        end
        exp_q.push_back(V_LMR);
        repeat (TMRD) exp_q.push_back(V_NOP);

        bad = 0;
        stall_left = 0;
        stalled = 1'b0;
        for (int i = 0; i < exp_q.size(); i++) begin
            @(negedge clk);
            if (i == 0 && v.chg_tms) bus.tms = 32'h0FF0_1FFF;
            obs = {bus.cmd_valid, bus.cmd};
            if (obs !== exp_q[i] || bus.cmd_cs !== oh || bus.bus_req !== 1'b1 ||
                bus.init_ack !== 8'h00 || bus.lmr_ack !== 8'h00 ||
                (obs == V_LMR && bus.mode_val !== v.tms[12:0])) begin
                if (bad == 0)
                    $display("trace diverges: sel=%0d cycle=%0d got=%h want=%h cs=%h mode=%h",
                             v.exp_sel, i, obs, exp_q[i], bus.cmd_cs, bus.mode_val);
                bad++;
            end
            if (stall_left > 0) begin
                stall_left--;
                if (stall_left == 0) bus.cmd_ready = 1'b1;
            end else if (v.stall > 0 && !stalled && obs == V_REF) begin
                stalled = 1'b1;
                stall_left = v.stall;
                bus.cmd_ready = 1'b0;
            end
        end
        chk("trace_errors", 64'(bad), 64'd0);

        @(negedge clk);
        chk("init_ack", 64'(bus.init_ack), v.exp_init ? 64'(oh) : 64'd0);
        chk("lmr_ack", 64'(bus.lmr_ack), v.exp_init ? 64'd0 : 64'(oh));
        chk("ack_cycle_bus", 64'({bus.bus_req, bus.cmd_valid, bus.cmd, bus.cmd_cs}), 64'd0);
        if (v.exp_init) init_pend &= ~oh;
        else            lmr_pend  &= ~oh;
        bus.init_req = init_pend;
        bus.lmr_req  = lmr_pend;
        bus.bus_gnt  = 1'b0;
        bus.cmd_ready = 1'b1;
        seqs++;
    endtask

    initial begin
        int   n;
        vec_t rv;
        bus.init_req  = '0;
        bus.lmr_req   = '0;
        bus.tms       = '0;
        bus.bus_gnt   = 1'b0;
        bus.cmd_ready = 1'b1;

        //            init   lmr    tms            sel  init stall chg lat
        vecs[0] = '{8'h04, 8'h00, 32'h0310_0123, 3'd2, 1'b1, 0, 1'b0, 1'b0};
        vecs[1] = '{8'h20, 8'h01, 32'h0120_0555, 3'd5, 1'b1, 0, 1'b0, 1'b0};
        vecs[2] = '{8'h00, 8'h00, 32'h0020_0AAA, 3'd0, 1'b0, 0, 1'b0, 1'b1};
        vecs[3] = '{8'h00, 8'h03, 32'h0010_0042, 3'd0, 1'b0, 0, 1'b0, 1'b1};
        vecs[4] = '{8'h00, 8'h00, 32'h0000_1FFF, 3'd1, 1'b0, 0, 1'b0, 1'b1};
        vecs[5] = '{8'h01, 8'h00, 32'h0000_0777, 3'd0, 1'b1, 5, 1'b0, 1'b0};
        vecs[6] = '{8'h80, 8'h00, 32'h0FF0_0ABC, 3'd7, 1'b1, 0, 1'b0, 1'b0};
        vecs[7] = '{8'h00, 8'h10, 32'h0020_1ABC, 3'd4, 1'b0, 0, 1'b1, 1'b0};

        repeat (3) @(negedge clk);
        chk("reset_outputs", 64'({bus.init_ack, bus.lmr_ack, bus.cs_sel, bus.bus_req, bus.cmd,
                                  bus.cmd_valid, bus.cmd_cs, bus.mode_val}), 64'd0);
        rst = 1'b1;
        @(negedge clk);

        for (int k = 0; k < 8; k++) serve(vecs[k]);

        // Reset landing in TRFC: outputs clear at once, request is re-served from scratch.
        init_pend |= 8'h02;
        bus.init_req = init_pend;
        bus.tms = 32'h0300_0000;
        n = 0;
        while (bus.bus_req !== 1'b1 && n < 40) begin
            @(negedge clk);
            n++;
        end
        chk("rst_seq_bus_req", 64'(bus.bus_req), 64'd1);
        @(negedge clk);
        bus.bus_gnt = 1'b1;
        n = 0;
        while ({bus.cmd_valid, bus.cmd} !== V_REF && n < 40) begin
            @(negedge clk);
            n++;
        end
        chk("rst_seq_reached_ref", 64'({bus.cmd_valid, bus.cmd}), 64'(V_REF));
        @(negedge clk);
        @(negedge clk);
        chk("rst_seq_in_trfc", 64'({bus.bus_req, bus.cmd_valid, bus.cmd_cs}), 64'h202);
        rst = 1'b0;
        #1;
        chk("async_reset_outputs", 64'({bus.init_ack, bus.lmr_ack, bus.cs_sel, bus.bus_req, bus.cmd,
                                        bus.cmd_valid, bus.cmd_cs, bus.mode_val}), 64'd0);
        bus.bus_gnt = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
        rv = '{8'h00, 8'h00, 32'h0300_0000, 3'd1, 1'b1, 0, 1'b0, 1'b0};
        serve(rv);

        repeat (4) @(negedge clk);
        chk("ack_pulse_total", 64'(ack_pulses), 64'(seqs));
        chk("multi_ack_cycles", 64'(multi_ack), 64'd0);
        chk("reqs_drained", 64'({init_pend, lmr_pend}), 64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
